// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = 12,
    parameter int unsigned AE_LEVEL   = 4,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_master,
    input  logic                  reset,
    input  logic                  wr_en_master,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en_slave,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] FullCount = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AfCount   = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AeCount   = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    always_comb begin
        // Acceptance uses the registered flags: no write-through when full, no read-through when empty.
        wr_acc      = wr_en_master & ~full_q;
        rd_acc      = rd_en_slave & ~empty_q;
        wr_ptr_d    = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error event beats a same-cycle clear.
        overflow_d  = clear_err ? 1'b0 : overflow_q;
        underflow_d = clear_err ? 1'b0 : underflow_q;
        if (wr_en_master && full_q) overflow_d = 1'b1;
        if (rd_en_slave && empty_q) underflow_d = 1'b1;
    end

    always_ff @(posedge clk_master) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == FullCount);
            empty_q     <= (count_d == '0);
            af_q        <= (count_d >= AfCount);
            ae_q        <= (count_d <= AeCount);
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_master) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out   = mem[rd_ptr_q];
    assign data_valid = ~empty_q;
`else
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;

    always_ff @(posedge clk_master) begin
        if (reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_acc;
            if (rd_acc) begin
                data_out_q <= mem[rd_ptr_q];
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DEPTH 16, AF 12, AE 4).
module tb_sync_fifo;

    logic       clk_master = 1'b0;
    logic       reset;
    logic       wr_en_master;
    logic [7:0] data_in;
    logic       rd_en_slave;
    logic       clear_err;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int n_checks = 0;
    int n_pass   = 0;

    sync_fifo dut (
        .clk_master   (clk_master),
        .reset        (reset),
        .wr_en_master (wr_en_master),
        .data_in      (data_in),
        .rd_en_slave  (rd_en_slave),
        .clear_err    (clear_err),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk_master = ~clk_master;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk_master);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d);
        wr_en_master = 1'b1;
        data_in      = d;
        tick();
        wr_en_master = 1'b0;
    endtask

    // Pops one word; FWFT presents it before the pop, registered mode one cycle after.
    task automatic do_read(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        check({tag, "_valid"}, 32'(data_valid), 32'd1);
        check({tag, "_data"}, 32'(data_out), 32'(exp));
        rd_en_slave = 1'b1;
        tick();
        rd_en_slave = 1'b0;
`else
        rd_en_slave = 1'b1;
        tick();
        rd_en_slave = 1'b0;
        check({tag, "_valid"}, 32'(data_valid), 32'd1);
        check({tag, "_data"}, 32'(data_out), 32'(exp));
`endif
    endtask

    initial begin
        reset = 1'b1; wr_en_master = 1'b0; data_in = '0; rd_en_slave = 1'b0; clear_err = 1'b0;
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rst_dout", 32'(data_out), 32'd0);
`endif
        reset = 1'b0;

        // Basic in-order transfer.
        do_write(8'h11);
        do_write(8'h22);
        do_write(8'h33);
        check("t1_count3", 32'(count), 32'd3);
        do_read("t1_r0", 8'h11);
        do_read("t1_r1", 8'h22);
        do_read("t1_r2", 8'h33);
        tick();
        check("t1_valid_off", 32'(data_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("t1_dout_hold", 32'(data_out), 32'h33);
`endif
        check("t1_count0", 32'(count), 32'd0);
        check("t1_empty", 32'(empty), 32'd1);

        // Fill to full, then one write too many.
        for (int i = 0; i < 16; i++) begin
            do_write(8'(i));
            check("t2_count", 32'(count), 32'(i + 1));
            check("t2_af", 32'(almost_full), 32'((i + 1) >= 12));
            check("t2_full", 32'(full), 32'((i + 1) == 16));
        end
        do_write(8'hAA);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_count16", 32'(count), 32'd16);

        // Simultaneous write+read while full: only the read goes through.
`ifdef SYNC_FIFO_FWFT_EN
        check("t3_data_pre", 32'(data_out), 32'h00);
`endif
        wr_en_master = 1'b1; data_in = 8'hBB; rd_en_slave = 1'b1;
        tick();
        wr_en_master = 1'b0; rd_en_slave = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
        check("t3_data", 32'(data_out), 32'h00);
        check("t3_valid", 32'(data_valid), 32'd1);
`endif
        check("t3_count15", 32'(count), 32'd15);
        check("t3_full", 32'(full), 32'd0);
        check("t3_ovf", 32'(overflow), 32'd1);
        for (int i = 1; i < 16; i++) do_read("t3_drain", 8'(i));
        check("t3_empty", 32'(empty), 32'd1);

        // Error flag clear and underflow.
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t4_ovf_clr", 32'(overflow), 32'd0);
        rd_en_slave = 1'b1;
        tick();
        rd_en_slave = 1'b0;
        check("t4_unf", 32'(underflow), 32'd1);
        check("t4_valid", 32'(data_valid), 32'd0);
        check("t4_count", 32'(count), 32'd0);
        rd_en_slave = 1'b1; clear_err = 1'b1;
        tick();
        rd_en_slave = 1'b0; clear_err = 1'b0;
        check("t4_set_wins", 32'(underflow), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("t4_unf_clr", 32'(underflow), 32'd0);

        // Wrap-around with almost_empty tracking.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 10; i++) begin
                do_write(8'(8'h40 + 8'(pass * 8'h40) + 8'(i)));
                check("t5_ae_fill", 32'(almost_empty), 32'((i + 1) <= 4));
            end
            for (int i = 0; i < 10; i++) begin
                do_read("t5_rd", 8'(8'h40 + 8'(pass * 8'h40) + 8'(i)));
                check("t5_ae_drain", 32'(almost_empty), 32'((9 - i) <= 4));
            end
        end
        check("t5_empty", 32'(empty), 32'd1);

        // Reset mid-stream with count 7 and an error flag set.
        rd_en_slave = 1'b1;
        tick();
        rd_en_slave = 1'b0;
        for (int i = 0; i < 7; i++) do_write(8'(8'hC0 + i));
        check("t6_count7", 32'(count), 32'd7);
        reset = 1'b1; wr_en_master = 1'b1; data_in = 8'hEE; rd_en_slave = 1'b1;
        tick();
        reset = 1'b0; wr_en_master = 1'b0; rd_en_slave = 1'b0;
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_valid", 32'(data_valid), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_unf", 32'(underflow), 32'd0);
        do_write(8'h5A);
        check("t6_count1", 32'(count), 32'd1);
        do_read("t6_rd", 8'h5A);
        check("t6_empty_end", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous FIFO directly downstream of the master write stage.
- Accepts the master's write strobe and byte on every clock; buffers up to DEPTH words; delivers them in order to the downstream slave/read side.
- Provides:
  - full/empty and almost-full/almost-empty flags, so the master and slave can throttle.
  - a live occupancy count.
  - sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out.
- DEPTH, 16, number of storage words; must be a power of two, minimum 4.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL.
- ADDR_WIDTH (localparam), log2(DEPTH), pointer index width.

Ports:
- clk_master  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en_master  in  1  write request from master stage.
- data_in  in  DATA_WIDTH  write data, sampled with wr_en_master.
- rd_en_slave  in  1  read request from downstream consumer.
- clear_err  in  1  synchronous clear of overflow/underflow.
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out holds a freshly read word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset (synchronous, takes priority over all other inputs, including mid-transfer):
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - data_out = 0, data_valid = 0, overflow = 0, underflow = 0.
  - Storage array is not reset; contents are don't-care after reset.
- Write accept: wr_en_master && !full.
  - mem[wr_ptr] <= data_in.
  - wr_ptr increments modulo DEPTH; natural wrap from DEPTH-1 to 0.
- Read accept: rd_en_slave && !empty.
  - rd_ptr increments modulo DEPTH.
- Acceptance is decided on the registered flags at the clock edge. There is no write-through when full and no read-through when empty.
- Count update:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged when both are accepted, or when neither is.
- Simultaneous requests:
  - When full: read accepted, write rejected, overflow set; count goes DEPTH -> DEPTH-1.
  - When empty: write accepted, read rejected, underflow set; count goes 0 -> 1.
- Flags are registered and computed from the next-state count, so they are coincident with count; no extra cycle of lag.
- Error flags:
  - overflow sets on wr_en_master && full.
  - underflow sets on rd_en_slave && empty.
  - Both hold until reset or clear_err.
  - If clear_err and a new error event occur in the same cycle, the set wins.
- Default read timing (macro undefined):
  - On an accepted read, data_out <= mem[rd_ptr] at that edge and data_valid = 1 for exactly one cycle.
  - Read latency is 1 cycle from the rd_en_slave sample.
  - When no read is accepted, data_valid = 0 and data_out holds its last value.
- A word written at edge N can be read by a request sampled at edge N+1 at the earliest.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out continuously presents mem[rd_ptr].
  - data_valid = !empty.
  - rd_en_slave acts as an acknowledge that pops the presented word; read latency is 0.
  - data_out is don't-care while empty.
  - The reset values of all flags are unchanged.
- Undefined: the registered 1-cycle-latency read path described in Behaviour.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles, then 3 reads -> data_out 0x11, 0x22, 0x33 each one cycle after its read, data_valid pulses 3 times, count returns 0, empty = 1.
- Write 16 words 0x00..0x0F -> almost_full asserts when count reaches 12, full = 1 at count 16; a 17th write -> overflow = 1, count stays 16, data 0x0F not overwritten.
- With full, assert wr_en_master and rd_en_slave together -> read returns 0x00, count 15, full = 0; the write is rejected and overflow is set.
- With empty, assert rd_en_slave alone -> underflow = 1, data_valid = 0, count 0; pulse clear_err -> underflow = 0 next cycle.
- Wrap-around: fill 10, read 10, fill 10 more, read 10 (pointers cross DEPTH-1 -> 0) -> output sequence matches input order; almost_empty deasserts at count 5 and reasserts at count 4.
- Assert reset mid-stream with count = 7 -> next cycle count 0, empty = 1, data_valid = 0, overflow/underflow = 0; the next write/read pair returns the new data. With SYNC_FIFO_FWFT_EN, the first written word appears on data_out with data_valid = 1 the cycle after the write.
